gc_ctrl_arbiter: RTL and testbench

- Shares the Garnet global-controller AXI4-lite control port (12-bit address, 32-bit data) among NUM_REQ requesters, e.g. host CPU config path and bitstream loader.
- Accepts simple command/response transactions and grants the port round-robin.
- Sequences the AR/R or AW/W handshakes with one transaction outstanding; a timeout guards against a hung controller.
- Sits between the SoC-side requesters and the Garnet axi4_ctrl_* pins.

---
 rtl/gc_ctrl_pkg.sv | 8 +
 rtl/rr_arbiter.sv | 25 ++
 rtl/gc_ctrl_arbiter.sv | 148 ++++++++++++++
 tb/tb_gc_ctrl_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/gc_ctrl_pkg.sv
// gc_ctrl_pkg: shared widths, state encoding and AXI response codes for the
// Garnet global-controller control-port arbiter.
package gc_ctrl_pkg;
   localparam int GC_ADDR_W = 12;
   localparam int GC_DATA_W = 32;
   localparam logic [1:0] RRESP_OKAY = 2'b00;
   typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_DATA, RESP} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant; picks the first request at or
// after the pointer, wrapping modulo NUM_REQ. One-hot (or zero) grant.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PW-1:0]      i_ptr,
   output logic [NUM_REQ-1:0] o_gnt
);
   logic [PW-1:0] w_k;

   // scan from the farthest offset down so the nearest request wins
   always_comb begin
      o_gnt = '0;
      w_k = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         w_k = PW'((int'(i_ptr) + i) % NUM_REQ);
         if (i_req[w_k]) begin
            o_gnt = '0;
            o_gnt[w_k] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/gc_ctrl_arbiter.sv
// gc_ctrl_arbiter: shares the Garnet AXI4-lite control port among NUM_REQ
// requesters, round-robin, one transaction outstanding, with a timeout.
module gc_ctrl_arbiter
   import gc_ctrl_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TO_W = 11
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ-1:0]             req_write,
   input  logic [NUM_REQ*GC_ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*GC_DATA_W-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [GC_DATA_W-1:0]           rsp_rdata,
   output logic                           rsp_err,
   output logic [GC_ADDR_W-1:0]           gc_araddr,
   output logic                           gc_arvalid,
   input  logic                           gc_arready,
   input  logic [GC_DATA_W-1:0]           gc_rdata,
   input  logic [1:0]                     gc_rresp,
   input  logic                           gc_rvalid,
   output logic                           gc_rready,
   output logic [GC_ADDR_W-1:0]           gc_awaddr,
   output logic                           gc_awvalid,
   input  logic                           gc_awready,
   output logic [GC_DATA_W-1:0]           gc_wdata,
   output logic                           gc_wvalid,
   input  logic                           gc_wready
);
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t                 r_state;
   logic [PW-1:0]          r_ptr;
   logic [NUM_REQ-1:0]     r_gnt, r_rsp_valid;
   logic [GC_ADDR_W-1:0]   r_addr;
   logic [GC_DATA_W-1:0]   r_wdata, r_rsp_rdata;
   logic [TO_W-1:0]        r_to;
   logic                   r_arvalid, r_awvalid, r_wvalid, r_rready, r_rsp_err;
   logic [NUM_REQ-1:0]     w_gnt;
   logic [PW-1:0]          w_idx;
   logic                   w_wr, w_to, w_wr_done;
   logic [GC_ADDR_W-1:0]   w_addr;
   logic [GC_DATA_W-1:0]   w_wdata;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr (
      .i_req (req_valid),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt)
   );

   always_comb begin
      w_idx = '0;
      w_wr = 1'b0;
      w_addr = '0;
      w_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (w_gnt[i]) begin
            w_idx = PW'(i);
            w_wr = req_write[i];
            w_addr = req_addr[i*GC_ADDR_W +: GC_ADDR_W];
            w_wdata = req_wdata[i*GC_DATA_W +: GC_DATA_W];
         end
   end

   assign w_to      = r_to >= TO_W'(TIMEOUT_CYCLES - 1);
   assign w_wr_done = (!r_awvalid || gc_awready) && (!r_wvalid || gc_wready);

   assign req_ready  = (r_state == IDLE) ? w_gnt : '0;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_rdata  = r_rsp_rdata;
   assign rsp_err    = r_rsp_err;
   assign gc_araddr  = r_addr;
   assign gc_awaddr  = r_addr;
   assign gc_wdata   = r_wdata;
   assign gc_arvalid = r_arvalid;
   assign gc_awvalid = r_awvalid;
   assign gc_wvalid  = r_wvalid;
   assign gc_rready  = r_rready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_ptr <= '0;
         r_gnt <= '0;
         r_addr <= '0;
         r_wdata <= '0;
         r_to <= '0;
         r_arvalid <= 1'b0;
         r_awvalid <= 1'b0;
         r_wvalid <= 1'b0;
         r_rready <= 1'b0;
         r_rsp_valid <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err <= 1'b0;
      end else begin
         r_rsp_valid <= '0;
         r_to <= (r_state == IDLE || r_state == RESP) ? '0 : r_to + 1'b1;
         case (r_state)
            IDLE: if (|req_valid) begin
               r_gnt <= w_gnt;
               r_ptr <= (w_idx == PW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
               r_addr <= w_addr;
               r_wdata <= w_wdata;
               r_awvalid <= w_wr;
               r_wvalid <= w_wr;
               r_arvalid <= !w_wr;
               r_state <= w_wr ? WRITE : RD_ADDR;
            end
            // each write channel retires on its own ready; done once both have
            WRITE: begin
               r_awvalid <= r_awvalid && !gc_awready && !w_to;
               r_wvalid <= r_wvalid && !gc_wready && !w_to;
               if (w_wr_done || w_to) begin
                  r_rsp_valid <= r_gnt;
                  r_rsp_err <= !w_wr_done;
                  r_rsp_rdata <= '0;
                  r_state <= RESP;
               end
            end
            RD_ADDR: begin
               r_arvalid <= !gc_arready && !w_to;
               if (gc_arready) begin
                  r_rready <= 1'b1;
                  r_state <= RD_DATA;
               end else if (w_to) begin
                  r_rsp_valid <= r_gnt;
                  r_rsp_err <= 1'b1;
                  r_rsp_rdata <= '0;
                  r_state <= RESP;
               end
            end
            RD_DATA: if (gc_rvalid || w_to) begin
               r_rready <= 1'b0;
               r_rsp_valid <= r_gnt;
               r_rsp_rdata <= gc_rvalid ? gc_rdata : '0;
               r_rsp_err <= !gc_rvalid || (gc_rresp != RRESP_OKAY);
               r_state <= RESP;
            end
            RESP: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gc_ctrl_arbiter.sv
// tb_gc_ctrl_arbiter: table-driven and randomized checks of gc_ctrl_arbiter
// against a transaction-level model with a scripted AXI responder.
module tb_gc_ctrl_arbiter;
   localparam int TO = 16;

   logic        clk, reset_n;
   logic [1:0]  req_valid, req_ready, req_write, rsp_valid;
   logic [23:0] req_addr;
   logic [63:0] req_wdata;
   logic [31:0] rsp_rdata, gc_rdata, gc_wdata;
   logic        rsp_err, gc_arvalid, gc_arready, gc_rvalid, gc_rready;
   logic        gc_awvalid, gc_awready, gc_wvalid, gc_wready;
   logic [11:0] gc_araddr, gc_awaddr;
   logic [1:0]  gc_rresp;

   int n_chk = 0, n_pass = 0, ptr = 0;

   typedef struct {
      logic [1:0]  mask;
      bit          wr;
      logic [11:0] addr;
      logic [31:0] wd;
      int          da, db;
      logic [31:0] rd;
      logic [1:0]  rr;
      bit          hang;
      int          e_gnt;
      bit          e_err;
      logic [31:0] e_rd;
      int          e_lat;
   } vec_t;

   vec_t tbl[9];

   gc_ctrl_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .gc_araddr(gc_araddr), .gc_arvalid(gc_arvalid), .gc_arready(gc_arready),
      .gc_rdata(gc_rdata), .gc_rresp(gc_rresp), .gc_rvalid(gc_rvalid), .gc_rready(gc_rready),
      .gc_awaddr(gc_awaddr), .gc_awvalid(gc_awvalid), .gc_awready(gc_awready),
      .gc_wdata(gc_wdata), .gc_wvalid(gc_wvalid), .gc_wready(gc_wready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // transaction-level expectation: grant by rotating priority, err from
   // timeout or bad rresp, latency from the handshake delays
   function automatic vec_t predict(input vec_t v, input int p);
      vec_t r = v;
      r.e_gnt = v.mask[p] ? p : 1 - p;
      r.e_err = v.hang || (!v.wr && v.rr != 2'b00);
      r.e_rd  = (v.wr || v.hang) ? 32'h0 : v.rd;
      r.e_lat = v.hang ? TO : v.wr ? ((v.da > v.db) ? v.da : v.db) + 1 : v.da + v.db + 2;
      return r;
   endfunction

   task automatic run_txn(input string tag, input vec_t v);
      int na = 0, nb = 0;
      bit done = 0, ok = 1;
      logic p_arv = 0, p_arr = 0, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0;
      logic [1:0] eg = 2'b01 << v.e_gnt;
      @(negedge clk);
      chk({tag, " idle_rsp"}, rsp_valid, 0);
      chk({tag, " idle_gc"}, {gc_arvalid, gc_awvalid, gc_wvalid, gc_rready}, 0);
      req_valid = v.mask;
      for (int i = 0; i < 2; i++) begin
         req_write[i] = (i == v.e_gnt) ? v.wr : !v.wr;
         req_addr[12*i +: 12] = (i == v.e_gnt) ? v.addr : ~v.addr;
         req_wdata[32*i +: 32] = (i == v.e_gnt) ? v.wd : ~v.wd;
      end
      #1 chk({tag, " grant"}, req_ready, eg);
      @(negedge clk);
      req_valid = v.mask & ~eg;
      for (int c = 0; c < 64 && !done; c++) begin
         if (rsp_valid != 2'b00) begin
            done = 1;
            chk({tag, " rsp_port"}, rsp_valid, eg);
            chk({tag, " rsp_rdata"}, rsp_rdata, v.e_rd);
            chk({tag, " rsp_err"}, rsp_err, v.e_err);
            chk({tag, " rsp_lat"}, c, v.e_lat);
            ok &= !(gc_arvalid || gc_awvalid || gc_wvalid || gc_rready) && req_ready == 2'b00;
            {gc_arready, gc_awready, gc_wready, gc_rvalid} = '0;
         end else begin
            ok &= (req_ready == 2'b00);
            if (gc_arvalid) ok &= (gc_araddr == v.addr);
            if (gc_awvalid) ok &= (gc_awaddr == v.addr);
            if (gc_wvalid) ok &= (gc_wdata == v.wd);
            ok &= v.wr ? !(gc_arvalid || gc_rready) : !(gc_awvalid || gc_wvalid);
            if (p_arv && c < TO) ok &= (gc_arvalid == !p_arr);
            if (p_awv && c < TO) ok &= (gc_awvalid == !p_awr);
            if (p_wv && c < TO) ok &= (gc_wvalid == !p_wr);
            gc_arready = gc_arvalid && !v.hang && na >= v.da;
            gc_awready = gc_awvalid && !v.hang && na >= v.da;
            if (gc_arvalid || gc_awvalid) na++;
            gc_wready = gc_wvalid && !v.hang && nb >= v.db;
            gc_rvalid = gc_rready && !v.hang && nb >= v.db;
            gc_rdata = gc_rvalid ? v.rd : ~v.rd;
            gc_rresp = gc_rvalid ? v.rr : 2'b11;
            if (gc_wvalid || gc_rready) nb++;
            {p_arv, p_arr, p_awv, p_awr, p_wv, p_wr} =
               {gc_arvalid, gc_arready, gc_awvalid, gc_awready, gc_wvalid, gc_wready};
            @(negedge clk);
         end
      end
      if (!done) chk({tag, " rsp_seen"}, 0, 1);
      chk({tag, " protocol"}, ok, 1);
      ptr = (v.e_gnt + 1) % 2;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t v;
      bit quiet;
      reset_n = 0;
      req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
      gc_arready = 0; gc_rdata = 0; gc_rresp = 0; gc_rvalid = 0;
      gc_awready = 0; gc_wready = 0;
      //         mask   wr addr     wdata         da db rdata         rr    hang gnt err e_rdata       lat
      tbl[0] = '{2'b01, 0, 12'h010, 32'h0,        2, 0, 32'hDEADBEEF, 2'b00, 0, 0, 0, 32'hDEADBEEF, 4};
      tbl[1] = '{2'b01, 1, 12'h0F0, 32'h12345678, 1, 4, 32'h0,        2'b00, 0, 0, 0, 32'h0,        5};
      tbl[2] = '{2'b10, 0, 12'h024, 32'h0,        0, 1, 32'hCAFEF00D, 2'b10, 0, 1, 1, 32'hCAFEF00D, 3};
      tbl[3] = '{2'b11, 1, 12'hABC, 32'h00000001, 0, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,        1};
      tbl[4] = '{2'b11, 0, 12'h555, 32'h0,        0, 0, 32'h55AA55AA, 2'b00, 0, 1, 0, 32'h55AA55AA, 2};
      tbl[5] = '{2'b01, 0, 12'h7FF, 32'h0,        0, 0, 32'hFFFFFFFF, 2'b00, 1, 0, 1, 32'h0,        16};
      tbl[6] = '{2'b01, 0, 12'h011, 32'h0,        1, 2, 32'h13579BDF, 2'b00, 0, 0, 0, 32'h13579BDF, 5};
      tbl[7] = '{2'b10, 1, 12'h200, 32'hA5A5A5A5, 0, 0, 32'h0,        2'b00, 1, 1, 1, 32'h0,        16};
      tbl[8] = '{2'b10, 1, 12'hFFF, 32'h87654321, 3, 0, 32'h0,        2'b00, 0, 1, 0, 32'h0,        4};

      @(negedge clk);
      chk("reset req_ready", req_ready, 0);
      chk("reset rsp_valid", rsp_valid, 0);
      chk("reset rsp_rdata", rsp_rdata, 0);
      chk("reset rsp_err", rsp_err, 0);
      chk("reset gc_valids", {gc_arvalid, gc_awvalid, gc_wvalid, gc_rready}, 0);
      chk("reset gc_addr_data", {gc_araddr, gc_awaddr, gc_wdata}, 0);
      @(negedge clk);
      reset_n = 1;

      foreach (tbl[i]) run_txn($sformatf("tbl%0d", i), tbl[i]);

      // both requesters always pending: grants must alternate 0,1,0,1
      for (int k = 0; k < 8; k++) begin
         v = '{2'b11, 0, 12'h100 + 12'(k), 32'h0, k % 3, (k + 1) % 3, $urandom, 2'b00, 0,
               k % 2, 0, 32'h0, 0};
         v.e_rd = v.rd;
         v.e_lat = v.da + v.db + 2;
         run_txn($sformatf("alt%0d", k), v);
      end

      // reset while waiting in the read-data phase
      @(negedge clk);
      req_valid = 2'b01; req_write = 2'b00; req_addr = 24'h000345;
      #1 chk("rst_seq grant", req_ready, 2'b01);
      @(negedge clk);
      req_valid = 2'b00;
      gc_arready = gc_arvalid;
      @(negedge clk);
      gc_arready = 0;
      chk("rst_seq rready", gc_rready, 1);
      #2 reset_n = 0;
      #1 chk("rst_seq async_clear", |{req_ready, rsp_valid, rsp_rdata, rsp_err, gc_araddr,
             gc_arvalid, gc_rready, gc_awaddr, gc_awvalid, gc_wdata, gc_wvalid}, 0);
      gc_rvalid = 1; gc_rdata = 32'h0BADF00D;
      repeat (2) @(negedge clk);
      reset_n = 1;
      quiet = 1;
      repeat (3) begin
         @(negedge clk);
         quiet &= (rsp_valid == 2'b00);
      end
      chk("rst_seq no_rsp", quiet, 1);
      gc_rvalid = 0;
      ptr = 0;
      v = predict('{2'b11, 0, 12'h3A0, 32'h0, 1, 1, 32'h600DCAFE, 2'b00, 0, 0, 0, 32'h0, 0}, ptr);
      run_txn("post_reset", v);

      for (int k = 0; k < 60; k++) begin
         v.mask = 2'($urandom_range(1, 3));
         v.wr   = 1'($urandom_range(0, 1));
         v.addr = 12'($urandom);
         v.wd   = $urandom;
         v.da   = $urandom_range(0, 4);
         v.db   = $urandom_range(0, 4);
         v.rd   = $urandom;
         v.rr   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         v.hang = ($urandom_range(0, 15) == 0);
         v = predict(v, ptr);
         run_txn($sformatf("rnd%0d", k), v);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
